rr_arbiter_8: RTL

- Eight-channel round-robin responder for the eight request lines that the design collapses through `or_gate_8`.
- Where `or_gate_8` only reports that some request is pending, this block decides which channel is served. It grants exactly one requester at a time and holds the grant until that requester completes.
- Service order rotates fairly, and a hold timeout protects against a stuck channel.
- Sits between the request sources and the shared resource they contend for.

---
 rtl/rr_arbiter_8_pkg.sv | 30 +++
 rtl/rr_arbiter_8_or_gate_8.sv | 16 +
 rtl/rr_arbiter_8.sv | 107 ++++++++++
 3 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the eight-channel round-robin arbiter:
// state encoding, channel count and the rotating-priority search.
package rr_arbiter_8_pkg;

    localparam int NCH         = 8;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Returns {found, index} of the first set request scanning ptr, ptr+1, ... modulo 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic       found;
        logic [2:0] idx;
        logic [2:0] sel;
        found = 1'b0;
        sel   = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/rr_arbiter_8_or_gate_8.sv
// Eight-input OR used to flag that at least one request line is pending.
module or_gate_8 (
    input  logic i_in0,
    input  logic i_in1,
    input  logic i_in2,
    input  logic i_in3,
    input  logic i_in4,
    input  logic i_in5,
    input  logic i_in6,
    input  logic i_in7,
    output logic o_y
);

    assign o_y = i_in0 | i_in1 | i_in2 | i_in3 | i_in4 | i_in5 | i_in6 | i_in7;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-channel round-robin arbiter: grants one requester until done, abort
// (request dropped) or hold timeout, then rotates priority past the served channel.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       any_req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    state_t        r_state;
    logic [2:0]    r_ptr;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_gnt;
    logic [2:0]    r_gnt_id;
    logic          r_busy;
    logic          r_timeout;

    logic          w_any_req;
    logic [3:0]    w_pick;
    logic          w_expire;
    logic          w_release;

    or_gate_8 u_or (
        .i_in0 (req[0]),
        .i_in1 (req[1]),
        .i_in2 (req[2]),
        .i_in3 (req[3]),
        .i_in4 (req[4]),
        .i_in5 (req[5]),
        .i_in6 (req[6]),
        .i_in7 (req[7]),
        .o_y   (w_any_req)
    );

    assign w_pick = rr_pick(req, r_ptr);

    // Hold-counter expiry; a zero TIMEOUT never expires.
    always_comb begin
        if (TIMEOUT != 0) begin
            w_expire = (r_cnt == CW'(TIMEOUT - 1));
        end else begin
            w_expire = 1'b0;
        end
    end

    assign w_release = done | ~req[r_gnt_id] | w_expire;

    // Arbitration FSM: state, priority pointer, hold counter and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
            r_gnt     <= 8'h00;
            r_gnt_id  <= 3'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt    <= 8'h01 << w_pick[2:0];
                        r_gnt_id <= w_pick[2:0];
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_gnt     <= 8'h00;
                        r_busy    <= 1'b0;
                        r_ptr     <= r_gnt_id + 3'd1;
                        r_state   <= ST_IDLE;
                        // Only a genuine expiry pulses; done and abort take precedence.
                        r_timeout <= ~done & req[r_gnt_id];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 8'h00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign any_req = w_any_req;
    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
